// File: rtl/shift_universal_seq.sv
// rtl/shift_universal_seq.sv - N-bit universal shift register with count-driven multi-cycle sequencer (optional rotates: SHIFT_ROTATE_EN)
module shift_universal_seq #(
    parameter int N  = 8,
    parameter int CW = 4
) (
    input  logic          Clk,
    input  logic          Rst_n,
    input  logic [N-1:0]  In,
    input  logic          IL,
    input  logic          IR,
    input  logic [2:0]    Mode,
    input  logic          Start,
    input  logic [CW-1:0] Count,
    output logic [N-1:0]  Out,
    output logic          Busy,
    output logic          Done
);

    localparam logic [2:0] MODE_LOAD = 3'b001;
    localparam logic [2:0] MODE_SHL  = 3'b010;
    localparam logic [2:0] MODE_SHR  = 3'b011;
    localparam logic [2:0] MODE_ROL  = 3'b100;
    localparam logic [2:0] MODE_ROR  = 3'b101;
    localparam logic [2:0] MODE_ASR  = 3'b110;

    typedef enum logic {
        IDLE,
        SHIFT
    } state_t;

    state_t        state_q, state_d;
    logic [N-1:0]  out_q, out_d;
    logic [CW-1:0] rem_q, rem_d;
    logic [2:0]    mode_q, mode_d;
    logic          done_q, done_d;

    // True for modes that run through the SHIFT state; rotates only exist when enabled
    function automatic logic is_shift_mode(input logic [2:0] md);
        case (md)
            MODE_SHL, MODE_SHR, MODE_ASR: is_shift_mode = 1'b1;
`ifdef SHIFT_ROTATE_EN
            MODE_ROL, MODE_ROR:           is_shift_mode = 1'b1;
`endif
            default:                      is_shift_mode = 1'b0;
        endcase
    endfunction

    // One single-bit step; serial fill bits come straight from the live inputs
    function automatic logic [N-1:0] step(input logic [2:0] md, input logic [N-1:0] v,
                                          input logic il, input logic ir);
        case (md)
            MODE_SHL: step = {v[N-2:0], ir};
            MODE_SHR: step = {il, v[N-1:1]};
            MODE_ASR: step = {v[N-1], v[N-1:1]};
`ifdef SHIFT_ROTATE_EN
            MODE_ROL: step = {v[N-2:0], v[N-1]};
            MODE_ROR: step = {v[0], v[N-1:1]};
`endif
            default:  step = v;
        endcase
    endfunction

    // Next-state and datapath: accept requests in IDLE, step once per edge in SHIFT
    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        rem_d   = rem_q;
        mode_d  = mode_q;
        done_d  = 1'b0;
        case (state_q)
            IDLE: begin
                if (Start) begin
                    if (Mode == MODE_LOAD) begin
                        out_d  = In;
                        done_d = 1'b1;
                    end else if (is_shift_mode(Mode) && (Count != '0)) begin
                        mode_d  = Mode;
                        rem_d   = Count;
                        state_d = SHIFT;
                    end else begin
                        // hold, reserved, disabled rotate, or zero-length shift
                        done_d = 1'b1;
                    end
                end
            end
            SHIFT: begin
                out_d = step(mode_q, out_q, IL, IR);
                rem_d = rem_q - 1'b1;
                if (rem_q == CW'(1)) begin
                    state_d = IDLE;
                    done_d  = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // State register with synchronous active-low reset overriding any request
    always_ff @(posedge Clk) begin
        if (!Rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            rem_q   <= '0;
            mode_q  <= '0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            rem_q   <= rem_d;
            mode_q  <= mode_d;
            done_q  <= done_d;
        end
    end

    assign Out  = out_q;
    assign Busy = (state_q == SHIFT);
    assign Done = done_q;

endmodule
